// File: rtl/fetch_mem_pkg.sv
//----------------------------------------------------------------------
// fetch_mem_pkg : shared widths, state encoding and types for the
//                 fetch-side instruction memory responder. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package fetch_mem_pkg;

  localparam int WORD_LEN       = 32;
  localparam int MEM_CELL_SIZE  = 8;
  localparam int CELLS_PER_WORD = WORD_LEN / MEM_CELL_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } imem_state_t;

  typedef logic [MEM_CELL_SIZE-1:0] cell_t;
  typedef logic [WORD_LEN-1:0]      word_t;

endpackage

`default_nettype wire

// File: rtl/byte_ram.sv
//----------------------------------------------------------------------
// byte_ram : DEPTH x WIDTH cell array, synchronous write, asynchronous
//            read, contents survive reset. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module byte_ram #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
//----------------------------------------------------------------------
// instr_mem_responder : serves word fetches by assembling cells one per
//                       cycle, with a byte-wide program load port. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module instr_mem_responder #(
  parameter int WORD_LEN      = 32,
  parameter int MEM_CELL_SIZE = 8,
  parameter int DEPTH         = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     getInstruction,
  input  logic [MEM_CELL_SIZE-1:0] address,
  output logic                     busy,
  output logic                     instr_valid,
  output logic [WORD_LEN-1:0]      instruction,
  output logic                     addr_err,
  input  logic                     load_en,
  input  logic [MEM_CELL_SIZE-1:0] load_addr,
  input  logic [MEM_CELL_SIZE-1:0] load_data
);

  import fetch_mem_pkg::*;

  localparam int LANES = WORD_LEN / MEM_CELL_SIZE;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [MEM_CELL_SIZE:0] DEPTH_W   = (MEM_CELL_SIZE+1)'(DEPTH);
  localparam logic [CNT_W-1:0]       LAST_LANE = CNT_W'(LANES - 1);

  imem_state_t               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MEM_CELL_SIZE-1:0]  base_q, base_d;
  logic [WORD_LEN-1:0]       shadow_q, shadow_d;
  logic [WORD_LEN-1:0]       instr_d;
  logic                      valid_d, err_d, busy_d;
  logic                      ram_we;
  logic                      req_ok, req_bad;
  logic [MEM_CELL_SIZE:0]    rd_sum;
  logic [MEM_CELL_SIZE-1:0]  rd_addr, rd_data;

  byte_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (MEM_CELL_SIZE),
    .ADDR_W (MEM_CELL_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Widened sum so the wrap past the top cell is an explicit modulo.
  always_comb begin
    rd_sum  = {1'b0, base_q} + {{(MEM_CELL_SIZE+1-CNT_W){1'b0}}, cnt_q};
    rd_addr = MEM_CELL_SIZE'(rd_sum % DEPTH_W);
  end

  always_comb begin
    req_ok  = getInstruction && (address[CNT_W-1:0] == '0);
    req_bad = getInstruction && (address[CNT_W-1:0] != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      shadow_q    <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      shadow_q    <= shadow_d;
      instruction <= instr_d;
      instr_valid <= valid_d;
      addr_err    <= err_d;
      busy        <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    shadow_d = shadow_q;
    instr_d  = instruction;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    ram_we   = 1'b0;

    case (state_q)
      IDLE: begin
        // A load owns the cycle; the requester keeps its request up.
        if (load_en) begin
          ram_we = 1'b1;
        end else if (req_bad) begin
          err_d = 1'b1;
        end else if (req_ok) begin
          base_d  = address;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        for (int k = 0; k < LANES; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            shadow_d[k*MEM_CELL_SIZE +: MEM_CELL_SIZE] = rd_data;
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_LANE) begin
          instr_d = shadow_d;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        if (req_bad) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (req_ok && !load_en) begin
          base_d  = address;
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
//----------------------------------------------------------------------
// tb_instr_mem_responder : directed bench for instr_mem_responder. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        getInstruction = 1'b0;
  logic [7:0]  address = 8'd0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'd0;
  logic [7:0]  load_data = 8'd0;
  logic        busy;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  instr_mem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .getInstruction (getInstruction),
    .address        (address),
    .busy           (busy),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .addr_err       (addr_err),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cell(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",  busy, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_err",   addr_err, 0);
    check("rst_instr", instruction, 32'h0);
    rst = 1'b1;

    // Program image
    load_cell(8'd0, 8'h13);   load_cell(8'd1, 8'h05);
    load_cell(8'd2, 8'hA0);   load_cell(8'd3, 8'h00);
    load_cell(8'd4, 8'hEF);   load_cell(8'd5, 8'hBE);
    load_cell(8'd6, 8'hAD);   load_cell(8'd7, 8'hDE);
    load_cell(8'd8, 8'h44);   load_cell(8'd9, 8'h33);
    load_cell(8'd10, 8'h22);  load_cell(8'd11, 8'h11);
    load_cell(8'd252, 8'h78); load_cell(8'd253, 8'h56);
    load_cell(8'd254, 8'h34); load_cell(8'd255, 8'h12);
    @(negedge clk);
    load_en = 1'b0;

    // Single fetch from address 0
    getInstruction = 1'b1;
    address        = 8'd0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("f0_valid_c%0d", c), instr_valid, (c == 5));
      check($sformatf("f0_busy_c%0d", c), busy, (c <= 5));
      if (c == 4) check("f0_instr_hidden", instruction, 32'h0);
      if (c == 5) check("f0_instr", instruction, 32'h00A00513);
      if (c == 1) getInstruction = 1'b0;
    end

    // Back-to-back fetches 0 then 4
    getInstruction = 1'b1;
    address        = 8'd0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check($sformatf("b2b_valid_c%0d", c), instr_valid, (c == 5 || c == 10));
      check($sformatf("b2b_busy_c%0d", c), busy, (c <= 10));
      if (c == 5)  check("b2b_instr0", instruction, 32'h00A00513);
      if (c == 10) check("b2b_instr1", instruction, 32'hDEADBEEF);
      if (c == 5) address = 8'd4;
      if (c == 6) getInstruction = 1'b0;
    end

    // Misaligned request
    getInstruction = 1'b1;
    address        = 8'd6;
    @(negedge clk);
    check("mis_err",   addr_err, 1);
    check("mis_valid", instr_valid, 0);
    check("mis_busy",  busy, 0);
    check("mis_instr", instruction, 32'hDEADBEEF);
    getInstruction = 1'b0;
    @(negedge clk);
    check("mis_err_clear", addr_err, 0);
    check("mis_busy2",     busy, 0);

    // Top-of-memory word
    getInstruction = 1'b1;
    address        = 8'd252;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) getInstruction = 1'b0;
    end
    check("top_valid", instr_valid, 1);
    check("top_instr", instruction, 32'h12345678);

    // Load and request together in IDLE; load during FETCH is dropped
    @(negedge clk);
    load_en        = 1'b1;
    load_addr      = 8'd8;
    load_data      = 8'hA5;
    getInstruction = 1'b1;
    address        = 8'd8;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("ct_valid_c%0d", c), instr_valid, (c == 6));
      check($sformatf("ct_busy_c%0d", c), busy, (c >= 2 && c <= 6));
      if (c == 6) check("ct_instr", instruction, 32'h112233A5);
      if (c == 1) load_en = 1'b0;
      if (c == 2) begin
        getInstruction = 1'b0;
        load_en        = 1'b1;
        load_addr      = 8'd9;
        load_data      = 8'h5A;
      end
      if (c == 3) load_en = 1'b0;
    end

    getInstruction = 1'b1;
    address        = 8'd8;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) getInstruction = 1'b0;
    end
    check("reread_valid", instr_valid, 1);
    check("reread_instr", instruction, 32'h112233A5);

    // Reset in the middle of a fetch
    @(negedge clk);
    getInstruction = 1'b1;
    address        = 8'd4;
    @(negedge clk);
    getInstruction = 1'b0;
    check("abort_busy_pre", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy",  busy, 0);
    check("abort_valid", instr_valid, 0);
    check("abort_instr", instruction, 32'h0);
    check("abort_err",   addr_err, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("post_valid_c%0d", c), instr_valid, 0);
      check($sformatf("post_busy_c%0d", c), busy, 0);
    end
    check("post_instr", instruction, 32'h0);

    // Memory survives reset
    getInstruction = 1'b1;
    address        = 8'd252;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) getInstruction = 1'b0;
    end
    check("keep_valid", instr_valid, 1);
    check("keep_instr", instruction, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Responder end of the fetch-side instruction interface. Serves word fetch requests from the fetch stage out of a byte-cell instruction memory.
- Assembles each 32-bit instruction from four 8-bit cells, one cell per cycle, then presents it with a one-cycle valid strobe.
- Includes a byte-wide load port so a testbench or boot loader can write the program image before execution.

Parameters:
- WORD_LEN, 32, instruction width in bits.
- MEM_CELL_SIZE, 8, memory cell width in bits; also the address width.
- DEPTH, 256, number of cells; must equal 2**MEM_CELL_SIZE.
- CELLS_PER_WORD, WORD_LEN/MEM_CELL_SIZE (4), derived constant; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- getInstruction  in  1  fetch request, level-sensitive; sampled only when accepting.
- address  in  MEM_CELL_SIZE  byte address of the requested word.
- busy  out  1  high while a fetch is in progress or its response is being presented.
- instr_valid  out  1  one-cycle strobe; instruction is new this cycle.
- instruction  out  WORD_LEN  last fetched word; held between responses.
- addr_err  out  1  one-cycle pulse on a misaligned request.
- load_en  in  1  program-load write enable.
- load_addr  in  MEM_CELL_SIZE  load cell address.
- load_data  in  MEM_CELL_SIZE  load cell data.

Behaviour:
- Reset: asserting rst low immediately forces the following, regardless of clock:
  - state=IDLE, busy=0, instr_valid=0, addr_err=0, instruction=0, cell counter=0.
  - Memory contents are not cleared.
  - An in-flight fetch is aborted with no instr_valid.
- FSM states: IDLE, FETCH, RESP.
- IDLE:
  - If load_en=1: write load_data to cell load_addr. No fetch is accepted that cycle; load has priority and the requester holds getInstruction.
  - Else if getInstruction=1 and address[1:0]!=0: pulse addr_err for 1 cycle, stay in IDLE, instruction unchanged.
  - Else if getInstruction=1: latch address as base, set counter=0, go to FETCH.
- FETCH (4 cycles):
  - Each cycle, register cell[(base+counter) mod DEPTH] into instruction byte lane counter (little-endian: lane k = bits [8k+7:8k]).
  - Counter increments each cycle. After lane 3 is captured, go to RESP.
  - Assembly uses a shadow register; the visible instruction updates only on entry to RESP.
- RESP (1 cycle):
  - instr_valid=1 and instruction holds the new word.
  - If getInstruction=1, load_en=0 and the address is aligned: accept the request and go directly to FETCH (back-to-back, 5 cycles per word).
  - If getInstruction=1 with a misaligned address: pulse addr_err in the next cycle and go to IDLE.
  - Otherwise go to IDLE.
- Latency: request accepted at edge N; instr_valid high in the cycle after edge N+4. Peak throughput is 1 word per 5 cycles.
- Outputs:
  - busy=1 in FETCH and RESP.
  - getInstruction and load_en are ignored during FETCH; writes during FETCH are dropped.
- Address wrap: base=252 fetches cells 252..255. Aligned bases never cross 255; the modulo is still implemented explicitly.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package fetch_mem_pkg holds:
  - WORD_LEN, MEM_CELL_SIZE, CELLS_PER_WORD.
  - typedef enum logic [1:0] {IDLE, FETCH, RESP} imem_state_t.
  - typedefs cell_t and word_t.
- Sub-module byte_ram: DEPTH x MEM_CELL_SIZE array, synchronous write, asynchronous read, no reset.
- instr_mem_responder contains the FSM, counter, shadow and output registers.

Test Plan:
- Reset: drive rst=0 mid-FETCH, then release → busy=0, instr_valid=0, instruction=0; no instr_valid for the aborted fetch.
- Load then fetch: load cells 0..3 = 0x13,0x05,0xA0,0x00; request address=0 → instr_valid exactly 5 cycles after acceptance, instruction=0x00A00513, busy high for cycles 1..5.
- Back-to-back: cells 4..7 = 0xEF,0xBE,0xAD,0xDE; hold getInstruction with address 0 then 4 → two strobes 5 cycles apart, values 0x00A00513 then 0xDEADBEEF.
- Misaligned: request address=6 → addr_err for exactly 1 cycle, no instr_valid, instruction unchanged, busy=0.
- Top cell: cells 252..255 = 0x78,0x56,0x34,0x12; request address=252 → instruction=0x12345678.
- Contention:
  - load_en with getInstruction in IDLE → write performed and fetch deferred one cycle.
  - load_en during FETCH → write ignored; verify by re-reading the target cell.
